systolic_mm_engine: RTL and testbench

Self-sequencing output-stationary MATRIX_SIZE x MATRIX_SIZE systolic matrix-multiply engine computing C = A x B for a runtime inner dimension K <= K_MAX.
- Accepts one A column and one B row per beat over a valid/ready stream.
- Applies the diagonal input skew internally, drains the array, then streams C out one row per beat.
- Sits between the operand buffers and the result writeback path; replaces hand-skewed array driving.

---
 rtl/systolic_pkg.sv | 50 +++++
 rtl/systolic_mm_engine_if.sv | 39 +++
 rtl/systolic_pe.sv | 43 ++++
 rtl/systolic_mm_engine.sv | 201 ++++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matrix-multiply engine.
// Optional build macro: SYSTOLIC_SIGNED_EN (two's complement operands when defined,
// unsigned operands otherwise). Supports DATA_WIDTH <= 32 and ACC_WIDTH <= 64.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  // Width of the k_len field: must hold every value 0..k_max.
  function automatic int k_len_width(input int k_max);
    return $clog2(k_max + 1);
  endfunction

  // Width of the result row index; never narrower than one bit.
  function automatic int row_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Cycles of zero feed needed for the last operand pair to reach PE(N-1,N-1).
  function automatic int drain_cycles(input int n);
    return 2 * n - 1;
  endfunction

  // Extend a dw-bit operand (held in the low bits of x) to 64 bits.
  function automatic logic [63:0] ext_operand(input logic [63:0] x, input int dw);
    logic [63:0] r;
    logic        fill;
`ifdef SYSTOLIC_SIGNED_EN
    fill = x[dw-1];
`else
    fill = 1'b0;
`endif
    for (int b = 0; b < 64; b++) begin
      r[b] = (b < dw) ? x[b] : fill;
    end
    return r;
  endfunction

  // Product of two dw-bit operands, extended to 64 bits. Taking the low
  // ACC_WIDTH bits gives the correctly extended product modulo 2^ACC_WIDTH.
  function automatic logic [63:0] prod_ext(input logic [63:0] a, input logic [63:0] b,
                                           input int dw);
    return ext_operand(a, dw) * ext_operand(b, dw);
  endfunction

endpackage

// File: rtl/systolic_mm_engine_if.sv
// Job control, operand stream and result stream of the systolic engine.
// Handshake rule for both streams: a beat transfers on a rising clock edge where
// valid && ready; the source holds data stable while valid && !ready, and ready
// never depends combinationally on valid.
interface systolic_mm_engine_if
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int K_MAX       = 16
);
  localparam int KW = k_len_width(K_MAX);
  localparam int RW = row_idx_width(MATRIX_SIZE);

  logic                                    start;
  logic [KW-1:0]                           k_len;
  logic                                    busy;
  logic                                    done;
  logic                                    in_valid;
  logic                                    in_ready;
  logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0]  a_col;
  logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0]  b_row;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [RW-1:0]                           out_row_idx;
  logic [MATRIX_SIZE-1:0][ACC_WIDTH-1:0]   out_row;

  modport slave (
    input  start, k_len, in_valid, a_col, b_row, out_ready,
    output busy, done, in_ready, out_valid, out_row_idx, out_row
  );

  modport master (
    output start, k_len, in_valid, a_col, b_row, out_ready,
    input  busy, done, in_ready, out_valid, out_row_idx, out_row
  );

endinterface

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell of the output-stationary array: forwards a to the
// right and b downward through registers and accumulates a*b in place.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_b,
  output logic [ACC_WIDTH-1:0]  o_acc
);

  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  w_prod;

  assign w_prod = ACC_WIDTH'(prod_ext(64'(i_a), 64'(i_b), DATA_WIDTH));

  // Operand forwarding and wrap-around accumulation; clear starts a new job.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= r_acc + w_prod;
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;

endmodule

// File: rtl/systolic_mm_engine.sv
// Self-sequencing N x N output-stationary systolic matrix multiplier, C = A x B.
// Takes one A column / B row per beat, skews lanes internally, drains the array,
// then streams C one row per beat. Optional build macro: SYSTOLIC_SIGNED_EN.
module systolic_mm_engine
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int K_MAX       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_mm_engine_if.slave  bus,
  output state_e               o_dbg_state
);

  localparam int N   = MATRIX_SIZE;
  localparam int KW  = k_len_width(K_MAX);
  localparam int RW  = row_idx_width(N);
  localparam int DC  = drain_cycles(N);
  localparam int DCW = $clog2(DC + 1);

  state_e          r_state;
  state_e          w_state_next;
  logic [KW-1:0]   r_k;
  logic [KW-1:0]   r_beat;
  logic [DCW-1:0]  r_drain_cnt;
  logic [RW-1:0]   r_row;
  logic            r_done;

  logic            w_start_job;
  logic            w_accept_in;
  logic            w_accept_out;
  logic            w_last_row;
  logic [KW-1:0]   w_k_clamped;

  assign w_k_clamped = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
  assign w_last_row  = (r_row == RW'(N - 1));

  // Next-state decode and handshake strobes.
  always_comb begin
    w_state_next = r_state;
    w_start_job  = 1'b0;
    w_accept_in  = 1'b0;
    w_accept_out = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_start_job  = 1'b1;
          w_state_next = (w_k_clamped == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          w_accept_in = 1'b1;
          if ((r_beat + KW'(1)) == r_k) w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (r_drain_cnt == DCW'(DC - 1)) w_state_next = OUTPUT;
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          w_accept_out = 1'b1;
          if (w_last_row) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register plus job length, beat, drain and row counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_beat      <= '0;
      r_drain_cnt <= '0;
      r_row       <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_accept_out && w_last_row;
      if (w_start_job) begin
        r_k    <= w_k_clamped;
        r_beat <= '0;
      end else if (w_accept_in) begin
        r_beat <= r_beat + KW'(1);
      end
      if (r_state == DRAIN) r_drain_cnt <= r_drain_cnt + DCW'(1);
      else                  r_drain_cnt <= '0;
      if (w_accept_out) r_row <= w_last_row ? '0 : r_row + RW'(1);
    end
  end

  // Lane feed: accepted beats enter the lanes, every other cycle feeds zeros.
  logic [DATA_WIDTH-1:0] w_feed_a [N];
  logic [DATA_WIDTH-1:0] w_feed_b [N];
  logic [DATA_WIDTH-1:0] w_lane_a [N];
  logic [DATA_WIDTH-1:0] w_lane_b [N];

  // Gate operands with the input accept strobe.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_feed_a[i] = w_accept_in ? bus.a_col[i] : '0;
      w_feed_b[i] = w_accept_in ? bus.b_row[i] : '0;
    end
  end

  // Diagonal skew: lane i is delayed by i cycles.
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign w_lane_a[i] = w_feed_a[i];
      assign w_lane_b[i] = w_feed_b[i];
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] r_dly_a [i];
      logic [DATA_WIDTH-1:0] r_dly_b [i];
      // Zero-reset shift register of depth i for this lane.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int d = 0; d < i; d++) begin
            r_dly_a[d] <= '0;
            r_dly_b[d] <= '0;
          end
        end else begin
          r_dly_a[0] <= w_feed_a[i];
          r_dly_b[0] <= w_feed_b[i];
          for (int d = 1; d < i; d++) begin
            r_dly_a[d] <= r_dly_a[d-1];
            r_dly_b[d] <= r_dly_b[d-1];
          end
        end
      end
      assign w_lane_a[i] = r_dly_a[i-1];
      assign w_lane_b[i] = r_dly_b[i-1];
    end
  end

  // PE grid: a flows along rows, b flows down columns.
  logic [DATA_WIDTH-1:0] w_pe_a_in  [N][N];
  logic [DATA_WIDTH-1:0] w_pe_b_in  [N][N];
  logic [DATA_WIDTH-1:0] w_pe_a_out [N][N];
  logic [DATA_WIDTH-1:0] w_pe_b_out [N][N];
  logic [ACC_WIDTH-1:0]  w_acc      [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign w_pe_a_in[i][j] = w_lane_a[i];
      end else begin : g_a_chain
        assign w_pe_a_in[i][j] = w_pe_a_out[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign w_pe_b_in[i][j] = w_lane_b[j];
      end else begin : g_b_chain
        assign w_pe_b_in[i][j] = w_pe_b_out[i-1][j];
      end
      systolic_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_start_job),
        .i_a     (w_pe_a_in[i][j]),
        .i_b     (w_pe_b_in[i][j]),
        .o_a     (w_pe_a_out[i][j]),
        .o_b     (w_pe_b_out[i][j]),
        .o_acc   (w_acc[i][j])
      );
    end
  end

  // Operands leaving the right and bottom edges of the array are not consumed.
  logic w_unused_edge;
  always_comb begin
    w_unused_edge = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_unused_edge = w_unused_edge ^ (^w_pe_a_out[k][N-1]) ^ (^w_pe_b_out[N-1][k]);
    end
  end

  // Result row mux: presents C[r] only while a row is offered, zeros otherwise.
  always_comb begin
    bus.out_row = '0;
    if (r_state == OUTPUT) begin
      for (int j = 0; j < N; j++) begin
        bus.out_row[j] = w_acc[r_row][j];
      end
    end
  end

  assign bus.busy        = (r_state != IDLE);
  assign bus.in_ready    = (r_state == LOAD);
  assign bus.out_valid   = (r_state == OUTPUT);
  assign bus.out_row_idx = r_row;
  assign bus.done        = r_done;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Bench for systolic_mm_engine: directed and randomized jobs checked against a
// plain matrix-product reference model with an expected-row queue.
`timescale 1ns/1ps
module tb_systolic_mm_engine;
  import systolic_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int KM = 16;
  localparam int KW = k_len_width(KM);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_mm_engine_if #(.MATRIX_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KM)) bus ();
  state_e dbg_state;

  systolic_mm_engine #(.MATRIX_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KM)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [N*AW-1:0] exp_q[$];
  logic [DW-1:0] mat_a [N][KM];
  logic [DW-1:0] mat_b [KM][N];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint op_val(input logic [DW-1:0] v);
`ifdef SYSTOLIC_SIGNED_EN
    return longint'($signed(v));
`else
    return longint'(v);
`endif
  endfunction

  function automatic logic [AW-1:0] ref_elem(input int i, input int j, input int k_eff);
    longint s;
    s = 0;
    for (int k = 0; k < k_eff; k++) s += op_val(mat_a[i][k]) * op_val(mat_b[k][j]);
    return s[AW-1:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic fill_identity();
    for (int k = 0; k < KM; k++)
      for (int i = 0; i < N; i++) begin
        mat_a[i][k] = (i == k) ? DW'(1) : DW'(0);
        mat_b[k][i] = DW'(k * N + i + 1);
      end
  endtask

  task automatic fill_random();
    for (int k = 0; k < KM; k++)
      for (int i = 0; i < N; i++) begin
        mat_a[i][k] = DW'($urandom);
        mat_b[k][i] = DW'($urandom);
      end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, " busy"}, bus.busy, 0);
    check_val({tag, " done"}, bus.done, 0);
    check_val({tag, " in_ready"}, bus.in_ready, 0);
    check_val({tag, " out_valid"}, bus.out_valid, 0);
    check_val({tag, " out_row_idx"}, bus.out_row_idx, 0);
    check_val({tag, " out_row"}, bus.out_row, 0);
    check_val({tag, " state"}, dbg_state, IDLE);
  endtask

  // Runs one job from a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic run_job(input string name, input int k_req, input int bubble_pct,
                         input bit stall_en, input bit poke_start);
    int k_eff, beats, rows, stall, dones, guard, present_cyc, first_lat;
    bit v, rdy, rdy_o, was_stalled;
    logic [N*AW-1:0] row, got_row, held_row;
    k_eff = (k_req > KM) ? KM : k_req;
    beats = 0; rows = 0; stall = 0; dones = 0; present_cyc = cyc; first_lat = -1;
    was_stalled = 0; held_row = '0;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) row[j*AW +: AW] = ref_elem(r, j, k_eff);
      exp_q.push_back(row);
    end
    bus.start = 1'b1;
    bus.k_len = KW'(k_req);
    @(negedge clk);
    bus.start = 1'b0;
    // operand beats
    guard = 0;
    while (beats < k_eff && guard < 400) begin
      v = ($urandom_range(99) >= bubble_pct);
      bus.in_valid = v;
      for (int i = 0; i < N; i++) begin
        bus.a_col[i] = v ? mat_a[i][beats] : DW'($urandom);
        bus.b_row[i] = v ? mat_b[beats][i] : DW'($urandom);
      end
      bus.start = poke_start && (beats == 1);
      bus.k_len = poke_start ? KW'(2) : KW'(k_req);
      rdy = bus.in_ready;
      if (v && beats == 0) present_cyc = cyc;
      @(negedge clk);
      if (v && rdy) beats++;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    check_val({name, " beats accepted"}, beats, k_eff);
    check_val({name, " in_ready after last beat"}, bus.in_ready, 0);
    // result rows
    guard = 0;
    while (rows < N && guard < 200) begin
      rdy_o = 1'b0;
      if (bus.done) dones++;
      if (bus.out_valid) begin
        if (first_lat < 0) first_lat = cyc - present_cyc;
        got_row = bus.out_row;
        check_val({name, " row idx"}, bus.out_row_idx, rows);
        check_val({name, " row data"}, got_row, exp_q[0]);
        if (was_stalled) check_val({name, " row stable while stalled"}, got_row, held_row);
        held_row = got_row;
        if (stall_en && stall < 3) begin
          bus.out_ready = 1'b0;
          stall++;
          was_stalled = 1'b1;
        end else begin
          bus.out_ready = 1'b1;
          stall = 0;
          was_stalled = 1'b0;
          rdy_o = 1'b1;
        end
      end else begin
        bus.out_ready = stall_en ? 1'($urandom_range(1)) : 1'b1;
      end
      @(negedge clk);
      if (rdy_o) begin
        rows++;
        void'(exp_q.pop_front());
      end
      guard++;
    end
    bus.out_ready = 1'b1;
    check_val({name, " rows delivered"}, rows, N);
    check_val({name, " done after last row"}, bus.done, 1);
    check_val({name, " busy after last row"}, bus.busy, 0);
    if (bus.done) dones++;
    @(negedge clk);
    if (bus.done) dones++;
    check_val({name, " done pulse count"}, dones, 1);
    if (bubble_pct == 0 && k_eff > 0)
      check_val({name, " first out_valid latency"}, first_lat, k_eff + 2 * N - 1);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.in_valid = 1'b0;
    bus.a_col = '0;
    bus.b_row = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    fill_identity();
    run_job("identity", 4, 0, 0, 0);

    for (int k = 0; k < KM; k++)
      for (int i = 0; i < N; i++) begin
        mat_a[i][k] = (k == 0) ? DW'(i + 1) : DW'(0);
        mat_b[k][i] = (k == 0) ? DW'(i + 4) : DW'(0);
      end
    run_job("outer", 1, 0, 0, 0);

    fill_identity();
    run_job("ident_bubble_stall", 4, 40, 1, 0);

    for (int k = 0; k < KM; k++)
      for (int i = 0; i < N; i++) begin
        mat_a[i][k] = 8'hFF;
        mat_b[k][i] = 8'd2;
      end
    run_job("signedness", 16, 0, 0, 0);

    run_job("k_zero", 0, 0, 0, 0);

    fill_random();
    run_job("k_clamp", 31, 0, 0, 0);

    fill_identity();
    run_job("start_in_load", 4, 0, 0, 1);

    // reset in the middle of LOAD after two beats
    fill_random();
    bus.start = 1'b1;
    bus.k_len = KW'(4);
    @(negedge clk);
    bus.start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        bus.a_col[i] = mat_a[i][b];
        bus.b_row[i] = mat_b[b][i];
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    check_idle_outputs("mid_load_reset");
    fill_identity();
    run_job("after_reset", 4, 0, 0, 0);

    for (int t = 0; t < 5; t++) begin
      fill_random();
      run_job("random", $urandom_range(KM, 1), 30, 1'($urandom_range(1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time limit in case the design stops responding altogether.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
